// File: rtl/ls_prog_loader.sv
// Local-store program loader: packs 32-bit words into 128-bit quadwords. Optional checksum via LS_PROG_LOADER_CHECKSUM_EN.
// Latency: 2 + 5N cycles from start to done for N quadwords when the stream and the grant never stall.
// Backpressure: in_ready is low outside FILL; a write waits in WRITE, with address and data held, until ls_gnt.
module ls_prog_loader #(
  parameter int LS_SIZE_BYTES = 32768,
  parameter int LS_ADDR_WD    = 32,
  parameter int CNT_WD        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [0:LS_ADDR_WD-1] base_addr,
  input  logic [0:CNT_WD-1]     num_qw,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:31]           in_data,
  output logic                  ls_req,
  input  logic                  ls_gnt,
  output logic [0:LS_ADDR_WD-1] ls_addr,
  output logic [0:127]          ls_data_wr,
  output logic                  ls_wr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [0:31]           checksum
);

  localparam int SUM_WD = LS_ADDR_WD + CNT_WD + 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [0:LS_ADDR_WD-1] addr_q, addr_d;
  logic [0:CNT_WD-1]     rem_q, rem_d;
  logic [1:0]            widx_q, widx_d;
  logic [0:127]          qw_buf_q, qw_buf_d;
  logic                  err_q, err_d;
  logic [SUM_WD-1:0]     end_addr;
  logic [SUM_WD-1:0]     size_lim;
  logic                  misaligned;

  // Wide enough that base + 16*count never wraps.
  assign end_addr   = SUM_WD'(addr_q) + (SUM_WD'(rem_q) << 4);
  assign size_lim   = SUM_WD'(LS_SIZE_BYTES);
  assign misaligned = (addr_q[LS_ADDR_WD-4:LS_ADDR_WD-1] != 4'b0);

`ifdef LS_PROG_LOADER_CHECKSUM_EN
  logic [0:31] csum_q, csum_d;
  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    widx_d   = widx_q;
    qw_buf_d = qw_buf_q;
    err_d    = err_q;
`ifdef LS_PROG_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CHECK;
          addr_d  = base_addr;
          rem_d   = num_qw;
          widx_d  = 2'd0;
          err_d   = 1'b0;
`ifdef LS_PROG_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_CHECK: begin
        if (misaligned || (end_addr > size_lim)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (in_valid) begin
          // Word 0 lands in bits 0:31, matching LS lane order.
          qw_buf_d[{widx_q, 5'b0} +: 32] = in_data;
          widx_d = widx_q + 2'd1;
`ifdef LS_PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q + in_data;
`endif
          if (widx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (ls_gnt) begin
          addr_d  = addr_q + LS_ADDR_WD'(16);
          rem_d   = rem_q - CNT_WD'(1);
          state_d = (rem_q == CNT_WD'(1)) ? S_DONE : S_FILL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      widx_q   <= 2'd0;
      qw_buf_q <= '0;
      err_q    <= 1'b0;
`ifdef LS_PROG_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      widx_q   <= widx_d;
      qw_buf_q <= qw_buf_d;
      err_q    <= err_d;
`ifdef LS_PROG_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign in_ready   = (state_q == S_FILL);
  assign ls_req     = (state_q == S_WRITE);
  assign ls_addr    = ls_req ? addr_q : '0;
  assign ls_data_wr = ls_req ? qw_buf_q : '0;
  assign ls_wr_en   = ls_req && ls_gnt;
  assign busy       = (state_q == S_CHECK) || (state_q == S_FILL) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err        = done && err_q;

endmodule

// File: tb/tb_ls_prog_loader.sv
// Directed bench for ls_prog_loader: packing, grant stalls, rejection, zero count, mid-run reset, checksum.
module tb_ls_prog_loader;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, ls_req, ls_gnt, ls_wr_en, busy, done, err;
  logic [0:AW-1] base_addr, ls_addr;
  logic [0:CW-1] num_qw;
  logic [0:31]   in_data, checksum;
  logic [0:127]  ls_data_wr;

  always #5 clk = ~clk;

  ls_prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_qw(num_qw),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ls_req(ls_req), .ls_gnt(ls_gnt), .ls_addr(ls_addr), .ls_data_wr(ls_data_wr),
    .ls_wr_en(ls_wr_en), .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, wr_cnt = 0, req_cnt = 0;
  logic         err_at_done = 1'b0, busy_at_done = 1'b0;
  logic [31:0]  csum_at_done = '0;
  logic [31:0]  wr_addr [16];
  logic [127:0] wr_data [16];
  logic [31:0]  exp_csum;

  // Edge monitor: records commands, writes and completions with a cycle stamp.
  always @(posedge clk) begin
    if (start && !busy && !done) start_cyc = cyc;
    if (ls_req) req_cnt++;
    if (ls_wr_en) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] = ls_addr;
        wr_data[wr_cnt] = ls_data_wr;
      end
      wr_cnt++;
    end
    if (done) begin
      done_cyc     = cyc;
      err_at_done  = err;
      busy_at_done = busy;
      csum_at_done = checksum;
      done_cnt++;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] b, input logic [15:0] n);
    base_addr = b;
    num_qw    = n;
    start     = 1'b1;
    tick;
    start     = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && k < 100) begin
      tick;
      k++;
    end
    if (!in_ready) chk("push_timeout", 128'(in_ready), 128'(1'b1));
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int k = 0;
    while (done_cnt == prev && k < 300) begin
      tick;
      k++;
    end
    chk("done_count", 128'(done_cnt), 128'(prev + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, d0, r0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    base_addr = '0; num_qw = '0; ls_gnt = 1'b1;
    tick; tick;
    chk("rst_ctl",  128'({in_ready, ls_req, ls_wr_en, busy, done, err}), 128'(6'b0));
    chk("rst_addr", 128'(ls_addr), 128'(0));
    chk("rst_data", 128'(ls_data_wr), 128'(0));
    chk("rst_csum", 128'(checksum), 128'(0));
    rst = 1'b0;
    tick;

    // Single quadword, grant always high.
    w0 = wr_cnt; d0 = done_cnt;
    issue(32'h100, 16'd1);
    chk("t1_busy_rise", 128'(busy), 128'(1'b1));
    push(32'h11111111); push(32'h22222222); push(32'h33333333); push(32'h44444444);
    wait_done(d0);
    chk("t1_nwr",    128'(wr_cnt - w0), 128'(1));
    chk("t1_addr",   128'(wr_addr[w0]), 128'(32'h100));
    chk("t1_data",   wr_data[w0], 128'h11111111222222223333333344444444);
    chk("t1_lat",    128'(done_cyc - start_cyc), 128'(7));
    chk("t1_err",    128'(err_at_done), 128'(1'b0));
    chk("t1_busy_dn", 128'(busy_at_done), 128'(1'b0));

    // Three quadwords with a 5-cycle grant stall on the second.
    w0 = wr_cnt; d0 = done_cnt;
    issue(32'h0, 16'd3);
    push(32'hA0000001); push(32'hA0000002); push(32'hA0000003); push(32'hA0000004);
    push(32'hB0000001); push(32'hB0000002); push(32'hB0000003); push(32'hB0000004);
    ls_gnt   = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_req",   128'(ls_req), 128'(1'b1));
      chk("t2_stall_addr",  128'(ls_addr), 128'(32'h10));
      chk("t2_stall_data",  ls_data_wr, 128'hB0000001B0000002B0000003B0000004);
      chk("t2_stall_ready", 128'(in_ready), 128'(1'b0));
      tick;
    end
    chk("t2_stall_nowr", 128'(wr_cnt - w0), 128'(1));
    in_valid = 1'b0;
    ls_gnt   = 1'b1;
    push(32'hC0000001); push(32'hC0000002); push(32'hC0000003); push(32'hC0000004);
    wait_done(d0);
    chk("t2_nwr",   128'(wr_cnt - w0), 128'(3));
    chk("t2_addr0", 128'(wr_addr[w0]),   128'(32'h0));
    chk("t2_addr1", 128'(wr_addr[w0+1]), 128'(32'h10));
    chk("t2_addr2", 128'(wr_addr[w0+2]), 128'(32'h20));
    chk("t2_data1", wr_data[w0+1], 128'hB0000001B0000002B0000003B0000004);
    chk("t2_data2", wr_data[w0+2], 128'hC0000001C0000002C0000003C0000004);
    chk("t2_err",   128'(err_at_done), 128'(1'b0));

    // Misaligned base is rejected.
    w0 = wr_cnt; d0 = done_cnt; r0 = req_cnt;
    issue(32'h104, 16'd1);
    wait_done(d0);
    chk("t3a_lat", 128'(done_cyc - start_cyc), 128'(2));
    chk("t3a_err", 128'(err_at_done), 128'(1'b1));
    chk("t3a_nwr", 128'(wr_cnt - w0), 128'(0));
    chk("t3a_req", 128'(req_cnt - r0), 128'(0));

    // End past the local store is rejected.
    d0 = done_cnt; r0 = req_cnt;
    issue(32'h7FF0, 16'd2);
    wait_done(d0);
    chk("t3b_err", 128'(err_at_done), 128'(1'b1));
    chk("t3b_req", 128'(req_cnt - r0), 128'(0));

    // Last quadword of the local store is legal.
    w0 = wr_cnt; d0 = done_cnt;
    issue(32'h7FF0, 16'd1);
    push(32'h01020304); push(32'h05060708); push(32'h090A0B0C); push(32'h0D0E0F10);
    wait_done(d0);
    chk("t3c_err",  128'(err_at_done), 128'(1'b0));
    chk("t3c_nwr",  128'(wr_cnt - w0), 128'(1));
    chk("t3c_addr", 128'(wr_addr[w0]), 128'(32'h7FF0));

    // Zero count completes cleanly without a request.
    d0 = done_cnt; r0 = req_cnt;
    issue(32'h40, 16'd0);
    wait_done(d0);
    chk("t4_lat", 128'(done_cyc - start_cyc), 128'(2));
    chk("t4_err", 128'(err_at_done), 128'(1'b0));
    chk("t4_req", 128'(req_cnt - r0), 128'(0));

    // Reset after two words aborts silently.
    w0 = wr_cnt; d0 = done_cnt;
    issue(32'h200, 16'd1);
    push(32'hEEEE0001); push(32'hEEEE0002);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t5_busy",  128'(busy), 128'(1'b0));
    chk("t5_ready", 128'(in_ready), 128'(1'b0));
    tick; tick; tick;
    chk("t5_nodone", 128'(done_cnt - d0), 128'(0));
    chk("t5_nowr",   128'(wr_cnt - w0), 128'(0));
    issue(32'h200, 16'd1);
    push(32'h5A5A0001); push(32'h5A5A0002); push(32'h5A5A0003); push(32'h5A5A0004);
    wait_done(d0);
    chk("t5_nwr",  128'(wr_cnt - w0), 128'(1));
    chk("t5_addr", 128'(wr_addr[w0]), 128'(32'h200));
    chk("t5_data", wr_data[w0], 128'h5A5A00015A5A00025A5A00035A5A0004);

    // Checksum wraps modulo 2^32.
`ifdef LS_PROG_LOADER_CHECKSUM_EN
    exp_csum = 32'h00000003;
`else
    exp_csum = 32'h00000000;
`endif
    d0 = done_cnt;
    issue(32'h300, 16'd1);
    push(32'hFFFFFFFF); push(32'h00000002); push(32'h00000001); push(32'h00000001);
    wait_done(d0);
    chk("t6_csum_done", 128'(csum_at_done), 128'(exp_csum));
    tick; tick;
    chk("t6_csum_hold", 128'(checksum), 128'(exp_csum));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ls_prog_loader.md
Name: ls_prog_loader

Overview:
- Host-side writer into the SPU local store. It is the write end of the LS port that fetch reads from.
- Accepts a load command (base address, quadword count) and a 32-bit word stream.
- Packs every 4 words into one 128-bit quadword and writes it to local store through an arbitrated request/grant port.
- Used to preload program and data images before or between pipeline runs.

Parameters:
- LS_SIZE_BYTES, 32768, local store size in bytes; the legal address range is 0..LS_SIZE_BYTES-1.
- LS_ADDR_WD, 32, local store address width (byte address).
- CNT_WD, 16, width of the quadword count field.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  [0:LS_ADDR_WD-1]  byte address of the first quadword.
- num_qw  input  [0:CNT_WD-1]  number of quadwords to write.
- in_valid  input  1  stream word valid.
- in_ready  output  1  stream word accepted when in_valid && in_ready.
- in_data  input  [0:31]  stream word.
- ls_req  output  1  request for the local store write port.
- ls_gnt  input  1  grant from the LS arbiter.
- ls_addr  output  [0:LS_ADDR_WD-1]  write address, quadword aligned.
- ls_data_wr  output  [0:127]  write data.
- ls_wr_en  output  1  write strobe.
- busy  output  1  high from command acceptance until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse with done on a rejected command.
- checksum  output  [0:31]  see Optional Feature.

Behaviour:
- Reset: all outputs are 0 and the FSM goes to IDLE.
  - Reset mid-operation discards any partial quadword and aborts without a write; no done pulse.
- FSM states: IDLE, CHECK, FILL, WRITE, DONE.
- IDLE -> CHECK on start. base_addr and num_qw are latched and busy rises the next cycle.
  - start in any other state is ignored.
- CHECK (1 cycle) rejects the command when base_addr[LS_ADDR_WD-4:LS_ADDR_WD-1] != 0 or base_addr + 16*num_qw > LS_SIZE_BYTES.
  - The sum is computed in LS_ADDR_WD+CNT_WD+4 bits so it cannot wrap.
  - Rejection: DONE with err=1 and no LS writes.
  - num_qw==0: DONE with err=0 and no LS writes.
  - Otherwise: FILL.
- FILL: in_ready=1.
  - The word index counts 0..3. Word k lands in qw_buf[32k:32k+31], so the first word occupies bits 0:31 (big-endian, matching the LS lane order).
  - On acceptance of word index 3 -> WRITE. in_ready drops the same cycle the FSM enters WRITE; no word is accepted in WRITE.
  - Stalls (in_valid=0) are held indefinitely.
- WRITE: ls_req=1, ls_addr=current address, ls_data_wr=qw_buf.
  - ls_wr_en = (state==WRITE) && ls_gnt, combinational from ls_gnt.
  - On ls_gnt:
    - address += 16;
    - remaining count -= 1;
    - go to DONE if remaining was 1, else back to FILL.
  - Without grant, hold: request, address and data stay stable.
- DONE (1 cycle): done=1, err as determined. busy=0 in this cycle. -> IDLE.
- Latency per quadword is at least 4 accept cycles + 1 write cycle. Minimum latency from start to done for N quadwords is 2 + 5N cycles.
- ls_addr and ls_data_wr are don't-care when ls_req=0; they are driven 0.

Optional Feature:
- Macro: LS_PROG_LOADER_CHECKSUM_EN.
- Defined:
  - checksum is cleared on command acceptance.
  - It is incremented modulo 2^32 by in_data on every accepted word.
  - The value is final and stable from the done pulse until the next start.
- Undefined: checksum is tied to 0 and no adder is built.

Test Plan:
- start, base_addr=0x100, num_qw=1, words 0x11111111,0x22222222,0x33333333,0x44444444 with ls_gnt=1 -> one ls_wr_en at ls_addr=0x100 with ls_data_wr=0x11111111222222223333333344444444; done at cycle 7 after start.
- num_qw=3 at base_addr=0x0, ls_gnt held 0 for 5 cycles on the second quadword -> ls_req, ls_addr=0x10 and ls_data_wr stay stable and in_ready=0; writes go to 0x0, 0x10, 0x20; then done.
- base_addr=0x104 -> err and done pulse 2 cycles after start, no ls_wr_en. base_addr=0x7FF0, num_qw=2 with LS_SIZE_BYTES=32768 -> err, no writes.
- num_qw=0 -> done with err=0, no ls_req.
- rst asserted after 2 of 4 words -> busy=0 next cycle, no write, no done. A following command of 1 quadword writes only the new 4 words.
- With LS_PROG_LOADER_CHECKSUM_EN: words 0xFFFFFFFF, 0x00000002, 0x1, 0x1 -> checksum=0x00000003 at done. Without the macro, checksum=0.
